// File: rtl/init_sequencer.sv
// init_sequencer: synchronises and glitch-filters init-done flags, then releases
// per-channel resets in index order with timeout and lost-done supervision.
module init_sequencer #(
   parameter int NUM_CH         = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_CYCLES  = 16,
   parameter int RELEASE_GAP    = 8,
   parameter int TIMEOUT_CYCLES = 1048576,
   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] done_in,
   input  logic [NUM_CH-1:0] ch_enable,
   input  logic              restart,
   output logic [NUM_CH-1:0] ch_resetn,
   output logic [NUM_CH-1:0] done_filt,
   output logic              all_done,
   output logic              timeout,
   output logic [IW-1:0]     timeout_ch,
   output logic              lost_done
);
   localparam int FW = $clog2(FILTER_CYCLES + 1);
   localparam int GW = (RELEASE_GAP > 0) ? $clog2(RELEASE_GAP + 1) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, WAIT, GAP, DONE, FAULT} state_t;

   logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
   logic [NUM_CH-1:0] synced;
   logic [NUM_CH-1:0] released;
   logic [IW-1:0] idx;
   logic [GW-1:0] gap_cnt;
   logic [TW-1:0] to_cnt;
   logic last, gap_end, to_hit, lost;
   state_t state;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync_q <= '0;
      else sync_q <= {sync_q[SYNC_STAGES-2:0], done_in};

   assign synced = sync_q[SYNC_STAGES-1];

   // rise needs FILTER_CYCLES consecutive synced highs; any low sample clears at once
   for (genvar c = 0; c < NUM_CH; c++) begin : g_filt
      logic [FW-1:0] cnt;
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) cnt <= '0;
         else cnt <= !synced[c] ? '0 : (cnt == FW'(FILTER_CYCLES)) ? cnt : cnt + 1'b1;
      assign done_filt[c] = cnt == FW'(FILTER_CYCLES);
   end

   assign last    = idx == IW'(NUM_CH - 1);
   assign gap_end = gap_cnt == GW'(RELEASE_GAP - 1);
   assign to_hit  = to_cnt == TW'(TIMEOUT_CYCLES - 1);
   assign lost    = (state == WAIT || state == GAP || state == DONE) && |(released & ch_enable & ~done_filt);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         released   <= '0;
         gap_cnt    <= '0;
         to_cnt     <= '0;
         ch_resetn  <= '0;
         all_done   <= 1'b0;
         timeout    <= 1'b0;
         timeout_ch <= '0;
         lost_done  <= 1'b0;
      end else if (restart) begin
         state      <= IDLE;
         ch_resetn  <= '0;
         all_done   <= 1'b0;
         timeout    <= 1'b0;
         timeout_ch <= '0;
         lost_done  <= 1'b0;
      end else if (lost) begin
         state     <= IDLE;
         ch_resetn <= '0;
         all_done  <= 1'b0;
         lost_done <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               idx      <= '0;
               released <= '0;
               to_cnt   <= '0;
               state    <= WAIT;
            end
            WAIT:
               if (ch_enable[idx] && to_hit) begin
                  state      <= FAULT;
                  timeout    <= 1'b1;
                  timeout_ch <= idx;
                  to_cnt     <= TW'(TIMEOUT_CYCLES);
               end else if (!ch_enable[idx] || done_filt[idx]) begin
                  ch_resetn[idx] <= 1'b1;
                  released[idx]  <= ch_enable[idx];
                  to_cnt         <= '0;
                  gap_cnt        <= '0;
                  // disabled channels and a zero gap advance without visiting GAP
                  if (ch_enable[idx] && RELEASE_GAP > 0) state <= GAP;
                  else begin
                     idx   <= last ? idx : idx + 1'b1;
                     state <= last ? DONE : WAIT;
                  end
               end else to_cnt <= to_cnt + 1'b1;
            GAP:
               if (gap_end) begin
                  idx    <= last ? idx : idx + 1'b1;
                  state  <= last ? DONE : WAIT;
                  to_cnt <= '0;
               end else gap_cnt <= gap_cnt + 1'b1;
            DONE: all_done <= 1'b1;
            default: ;
         endcase
      end
endmodule
